// File: rtl/issue_scoreboard.sv
// Single-slot RV64 issue stage with a register scoreboard that blocks RAW/WAW hazards
// until writeback, plus a pass-through register-file write port.
module issue_scoreboard #(
  parameter int unsigned N    = 32,
  parameter int unsigned Bits = 64,
  localparam int unsigned P   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_valid,
  input  logic [31:0]     inst,
  output logic            inst_ready,
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [P-1:0]    ptr_rd_1,
  output logic [P-1:0]    ptr_rd_2,
  output logic [P-1:0]    iss_rd,
  output logic            iss_wr_rd,
  output logic [6:0]      iss_opcode,
  output logic [2:0]      iss_funct3,
  output logic [Bits-1:0] iss_imm,
  output logic            iss_illegal,
  input  logic            wb_valid,
  input  logic [P-1:0]    wb_rd,
  input  logic [Bits-1:0] wb_data,
  output logic [P-1:0]    ptr_wr,
  output logic [Bits-1:0] data_wr,
  output logic            wr_en,
  output logic [31:0]     stall_cnt
);

  logic [6:0]      opcode;
  logic            use_rs1, use_rs2, use_rd, illegal;
  logic [31:0]     imm32;
  logic [Bits-1:0] imm_ext;
  logic [P-1:0]    rs1_f, rs2_f, rd_f;
  logic            wr_rd, hazard, accept;

  logic [N-1:0]    busy_q, busy_d;
  logic            iss_valid_q;
  logic [P-1:0]    rs1_q, rs2_q, rd_q;
  logic            wr_rd_q, illegal_q;
  logic [6:0]      opcode_q;
  logic [2:0]      funct3_q;
  logic [Bits-1:0] imm_q;
  logic [31:0]     stall_cnt_q;

  assign opcode = inst[6:0];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    illegal = 1'b0;
    imm32   = '0;
    case (opcode)
      7'b0110011, 7'b0111011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        imm32   = {{20{inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        use_rd = 1'b1;
        imm32  = {inst[31:12], 12'b0};
      end
      7'b1101111: begin
        use_rd = 1'b1;
        imm32  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  assign imm_ext = Bits'($signed(imm32));

  // Unused register fields are zeroed so they never alias a busy register.
  assign rs1_f = use_rs1 ? P'(inst[19:15]) : '0;
  assign rs2_f = use_rs2 ? P'(inst[24:20]) : '0;
  assign rd_f  = use_rd  ? P'(inst[11:7])  : '0;
  assign wr_rd = use_rd && (rd_f != '0);

  // Registered busy only: a writeback clear is seen by the check one cycle later.
  assign hazard = (use_rs1 && busy_q[rs1_f]) ||
                  (use_rs2 && busy_q[rs2_f]) ||
                  (wr_rd   && busy_q[rd_f]);

  assign inst_ready = (!iss_valid_q || iss_ready) && !hazard;
  assign accept     = inst_valid && inst_ready;

  // Clear first, then set, so a same-index set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rd] = 1'b0;
    if (accept && wr_rd) busy_d[rd_f] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      iss_valid_q <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      wr_rd_q     <= 1'b0;
      illegal_q   <= 1'b0;
      opcode_q    <= '0;
      funct3_q    <= '0;
      imm_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        iss_valid_q <= 1'b1;
        rs1_q       <= rs1_f;
        rs2_q       <= rs2_f;
        rd_q        <= rd_f;
        wr_rd_q     <= wr_rd;
        illegal_q   <= illegal;
        opcode_q    <= opcode;
        funct3_q    <= inst[14:12];
        imm_q       <= imm_ext;
      end else if (iss_ready) begin
        iss_valid_q <= 1'b0;
      end
      if (inst_valid && hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign iss_valid   = iss_valid_q;
  assign ptr_rd_1    = rs1_q;
  assign ptr_rd_2    = rs2_q;
  assign iss_rd      = rd_q;
  assign iss_wr_rd   = wr_rd_q;
  assign iss_opcode  = opcode_q;
  assign iss_funct3  = funct3_q;
  assign iss_imm     = imm_q;
  assign iss_illegal = illegal_q;
  assign stall_cnt   = stall_cnt_q;

  assign ptr_wr  = wb_rd;
  assign data_wr = wb_data;
  assign wr_en   = wb_valid && (wb_rd != '0);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: hand-written hazard/hold/reset sequences plus a decode table,
// with issued slots checked against a queue of expected records.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, iss_ready, wb_valid;
  logic [31:0] inst;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        inst_ready, iss_valid, iss_wr_rd, iss_illegal, wr_en;
  logic [4:0]  ptr_rd_1, ptr_rd_2, iss_rd, ptr_wr;
  logic [6:0]  iss_opcode;
  logic [2:0]  iss_funct3;
  logic [63:0] iss_imm, data_wr;
  logic [31:0] stall_cnt;

  issue_scoreboard #(.N(32), .Bits(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_ready (inst_ready),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .ptr_rd_1   (ptr_rd_1),
    .ptr_rd_2   (ptr_rd_2),
    .iss_rd     (iss_rd),
    .iss_wr_rd  (iss_wr_rd),
    .iss_opcode (iss_opcode),
    .iss_funct3 (iss_funct3),
    .iss_imm    (iss_imm),
    .iss_illegal(iss_illegal),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .ptr_wr     (ptr_wr),
    .data_wr    (data_wr),
    .wr_en      (wr_en),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rs1, rs2, rd;
    logic        wr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t exp_q[$];
  vec_t cur_exp;
  vec_t mon_e;
  vec_t tbl[12];

  function automatic vec_t mk(logic [31:0] i, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                              logic wr, logic [6:0] op, logic [2:0] f3, logic [63:0] imm,
                              logic ill);
    vec_t v;
    v.inst = i; v.rs1 = r1; v.rs2 = r2; v.rd = rd; v.wr = wr;
    v.op = op; v.f3 = f3; v.imm = imm; v.ill = ill;
    return v;
  endfunction

  function automatic logic [90:0] pk(vec_t v);
    return {v.rs1, v.rs2, v.rd, v.wr, v.op, v.f3, v.imm, v.ill};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_slot(input string nm, input vec_t e);
    logic [90:0] act;
    act = {ptr_rd_1, ptr_rd_2, iss_rd, iss_wr_rd, iss_opcode, iss_funct3, iss_imm, iss_illegal};
    total++;
    if (act !== pk(e)) begin
      bad++;
      $display("FAIL %s inst=%08h: got %h want %h", nm, e.inst, act, pk(e));
    end
  endtask

  task automatic drive(input vec_t e);
    inst       = e.inst;
    inst_valid = 1'b1;
    cur_exp    = e;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    #1;
    while (!inst_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (!inst_ready) begin
      bad++;
      $display("FAIL %s: inst_ready still 0 after %0d cycles, want 1", nm, n);
    end
  endtask

  // Scoreboard: pop on slot handshake, push on instruction accept.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      if (iss_valid && iss_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL slot_unexpected: got issue of opcode %0h, want none", iss_opcode);
        end else begin
          mon_e = exp_q.pop_front();
          chk_slot("slot", mon_e);
        end
      end
      if (inst_valid && inst_ready) exp_q.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  vec_t v_nop, v_ill, v_x7, v_x8, v_x31, v_x1, v_x9, v_x10;

  initial begin
    tbl[0]  = mk(32'h00100293, 0, 0, 5, 1, 7'h13, 0, 64'd1, 0);
    tbl[1]  = mk(32'h00528333, 5, 5, 6, 1, 7'h33, 0, 64'd0, 0);
    tbl[2]  = mk(32'hFE20AE23, 1, 2, 0, 0, 7'h23, 2, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    tbl[3]  = mk(32'hFE208CE3, 1, 2, 0, 0, 7'h63, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    tbl[4]  = mk(32'h80000537, 0, 0, 10, 1, 7'h37, 0, 64'hFFFF_FFFF_8000_0000, 0);
    tbl[5]  = mk(32'hFFFFF0EF, 0, 0, 1, 1, 7'h6F, 7, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    tbl[6]  = mk(32'h00001197, 0, 0, 3, 1, 7'h17, 1, 64'h1000, 0);
    tbl[7]  = mk(32'h00813203, 2, 0, 4, 1, 7'h03, 3, 64'd8, 0);
    tbl[8]  = mk(32'h009403BB, 8, 9, 7, 1, 7'h3B, 0, 64'd0, 0);
    tbl[9]  = mk(32'h00008067, 1, 0, 0, 0, 7'h67, 0, 64'd0, 0);
    tbl[10] = mk(32'hFFFFFFFF, 0, 0, 0, 0, 7'h7F, 7, 64'd0, 1);
    tbl[11] = mk(32'hFFF6059B, 12, 0, 11, 1, 7'h1B, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    v_nop = mk(32'h00000013, 0, 0, 0, 0, 7'h13, 0, 64'd0, 0);
    v_ill = tbl[10];
    v_x7  = mk(32'h00000393, 0, 0, 7, 1, 7'h13, 0, 64'd0, 0);
    v_x8  = mk(32'h00038413, 7, 0, 8, 1, 7'h13, 0, 64'd0, 0);
    v_x31 = mk(32'h000F8F93, 31, 0, 31, 1, 7'h13, 0, 64'd0, 0);
    v_x1  = mk(32'h00030093, 6, 0, 1, 1, 7'h13, 0, 64'd0, 0);
    v_x9  = mk(32'h00100493, 0, 0, 9, 1, 7'h13, 0, 64'd1, 0);
    v_x10 = mk(32'h00048513, 9, 0, 10, 1, 7'h13, 0, 64'd0, 0);

    rst = 1'b0; inst_valid = 1'b0; inst = '0; iss_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; cur_exp = v_nop;
    repeat (3) @(negedge clk);
    chk("rst_iss_valid", 64'(iss_valid), 0);
    chk("rst_stall_cnt", 64'(stall_cnt), 0);
    rst = 1'b1;
    #1;
    chk("rel_iss_valid", 64'(iss_valid), 0);
    chk("rel_inst_ready", 64'(inst_ready), 1);
    chk("rel_stall_cnt", 64'(stall_cnt), 0);
    chk("rel_wr_en", 64'(wr_en), 0);

    // addi x5 then a dependent add: stall until x5 is written back.
    @(negedge clk); iss_ready = 1'b1; drive(tbl[0]);
    #1 chk("addi_ready", 64'(inst_ready), 1);
    @(negedge clk);
    chk("addi_valid", 64'(iss_valid), 1);
    chk("addi_rd", 64'(iss_rd), 5);
    chk("addi_imm", iss_imm, 1);
    chk("addi_wr_rd", 64'(iss_wr_rd), 1);
    drive(tbl[1]);
    #1 chk("raw_blocked", 64'(inst_ready), 0);
    @(negedge clk); chk("stall_1", 64'(stall_cnt), 1);
    @(negedge clk); chk("stall_2", 64'(stall_cnt), 2);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'h1;
    #1 chk("no_bypass", 64'(inst_ready), 0);
    @(negedge clk); wb_valid = 1'b0; iss_ready = 1'b0;
    chk("stall_3", 64'(stall_cnt), 3);
    #1 chk("wb_unblocks", 64'(inst_ready), 1);
    @(negedge clk);
    chk("add_valid", 64'(iss_valid), 1);
    chk("add_ptrs", 64'({ptr_rd_1, ptr_rd_2}), 64'({5'd5, 5'd5}));
    drive(v_nop);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk_slot("hold_fields", tbl[1]);
      chk("hold_valid", 64'(iss_valid), 1);
      chk("hold_ready", 64'(inst_ready), 0);
      @(negedge clk);
    end
    chk("hold_stall_cnt", 64'(stall_cnt), 3);
    iss_ready = 1'b1;
    #1 chk("drain_ready", 64'(inst_ready), 1);

    // addi x0: no register write; wb to x0 never writes.
    @(negedge clk); inst_valid = 1'b0;
    chk("nop_wr_rd", 64'(iss_wr_rd), 0);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'h55;
    #1 chk("wb_x0_wr_en", 64'(wr_en), 0);

    // Same-edge set of x7 by accept and clear of x7 by writeback: set wins.
    @(negedge clk); wb_rd = 5'd7; wb_data = 64'hDEAD; drive(v_x7);
    #1;
    chk("wb_wr_en", 64'(wr_en), 1);
    chk("wb_ptr_wr", 64'(ptr_wr), 7);
    chk("wb_data_wr", data_wr, 64'hDEAD);
    chk("x7_ready", 64'(inst_ready), 1);
    @(negedge clk); wb_valid = 1'b0; drive(v_ill);
    #1 chk("ill_ready", 64'(inst_ready), 1);
    @(negedge clk);
    chk("ill_flag", 64'(iss_illegal), 1);
    chk("ill_wr_rd", 64'(iss_wr_rd), 0);
    drive(v_x8);
    #1 chk("set_wins", 64'(inst_ready), 0);
    drive(v_x31);
    #1 chk("ill_no_busy", 64'(inst_ready), 1);
    @(negedge clk); drive(v_x1);
    #1 chk("x6_still_busy", 64'(inst_ready), 0);

    // Reset mid-operation with a held slot and pending busy bits.
    @(negedge clk); iss_ready = 1'b0; drive(v_x9);
    #1 chk("x9_ready", 64'(inst_ready), 1);
    @(negedge clk); inst_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(iss_valid), 0);
    chk("mid_rst_stall", 64'(stall_cnt), 0);
    chk("mid_rst_rd", 64'(iss_rd), 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b1; iss_ready = 1'b1; drive(v_x10);
    #1 chk("busy_flushed", 64'(inst_ready), 1);
    @(negedge clk); inst_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd10;
    @(negedge clk); wb_valid = 1'b0;

    // Decode table, each destination written back before the next entry.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      wait_ready("tbl_ready");
      @(negedge clk);
      inst_valid = 1'b0;
      if (tbl[i].wr) begin
        wb_valid = 1'b1; wb_rd = tbl[i].rd; wb_data = 64'(i);
        @(negedge clk);
        wb_valid = 1'b0;
      end
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
